// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions and the EPC helper.
// Optional timer registers are enabled by defining CP0_TIMER_INT_EN.
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [4:0] EXCINT = 5'd0;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic ids);
    return (ids ? pc - 32'd4 : pc) & ~32'h3;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0: Count free-runs, pending latches on a match.
// Only instantiated when CP0_TIMER_INT_EN is defined.
module cp0_timer
  import cp0_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    pending_d = pending_q;
    if (count_q == compare_q) pending_d = 1'b1;
    if (we_i && waddr_i == CP0_COUNT) count_d = wdata_i;
    // Rewriting Compare acknowledges the timer, even against a same-edge match.
    if (we_i && waddr_i == CP0_COMPARE) begin
      compare_d = wdata_i;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller beside the M stage; requestInt is same-cycle combinational.
// Define CP0_TIMER_INT_EN to add Count/Compare driving HWInt[5].
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h2022_1108,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        CP0WE,
  input  logic [31:0] PC,
  input  logic        isIDS,
  input  logic [4:0]  excCode,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        requestInt,
  output logic [31:0] handlerPC
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  hw_int;
  logic        int_req, exc_req, mtc0_we;
  logic [31:0] sr_rd, cause_rd;

  assign mtc0_we = CP0WE & ~requestInt;

`ifdef CP0_TIMER_INT_EN
  logic [31:0] count, compare;
  logic        timer_pending;

  cp0_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .we_i      (mtc0_we),
    .waddr_i   (A2),
    .wdata_i   (DIn),
    .count_o   (count),
    .compare_o (compare),
    .pending_o (timer_pending)
  );

  assign hw_int = HWInt | {timer_pending, 5'b0};
`else
  assign hw_int = HWInt;
`endif

  assign int_req    = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req    = (excCode != EXCINT) & ~exl_q;
  assign requestInt = int_req | exc_req;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_int;
    exc_d = exc_q;
    epc_d = epc_q;
    if (requestInt) begin
      exl_d = 1'b1;
      exc_d = int_req ? EXCINT : excCode;
      bd_d  = isIDS;
      epc_d = epc_target(PC, isIDS);
    end else begin
      if (mtc0_we && A2 == CP0_SR) begin
        im_d  = DIn[SR_IM_LO +: 6];
        exl_d = DIn[SR_EXL];
        ie_d  = DIn[SR_IE];
      end
      if (mtc0_we && A2 == CP0_EPC) epc_d = DIn;
      // eret overrides a same-edge SR write for the EXL bit only.
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    sr_rd                         = '0;
    sr_rd[SR_IM_LO +: 6]          = im_q;
    sr_rd[SR_EXL]                 = exl_q;
    sr_rd[SR_IE]                  = ie_q;
    cause_rd                      = '0;
    cause_rd[CAUSE_BD]            = bd_q;
    cause_rd[CAUSE_IP_LO +: 6]    = ip_q;
    cause_rd[CAUSE_EXC_LO +: 5]   = exc_q;
  end

  always_comb begin
    DOut = '0;
    case (A1)
      CP0_SR:      DOut = sr_rd;
      CP0_CAUSE:   DOut = cause_rd;
      CP0_EPC:     DOut = epc_q;
      CP0_PRID:    DOut = PRID;
`ifdef CP0_TIMER_INT_EN
      CP0_COUNT:   DOut = count;
      CP0_COMPARE: DOut = compare;
`else
      CP0_COUNT, CP0_COMPARE: DOut = '0;
`endif
      default:     DOut = '0;
    endcase
  end

  assign EPCOut    = epc_q;
  assign handlerPC = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Randomized and directed bench for cp0_ctrl against a register-level reference model.
// Define CP0_TIMER_INT_EN to also exercise the Count/Compare timer.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, excCode;
  logic [31:0] DIn, PC;
  logic        CP0WE, isIDS, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPCOut, handlerPC;
  logic        requestInt;

  int n_vec = 0;
  int n_err = 0;

  cp0_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .A1         (A1),
    .A2         (A2),
    .DIn        (DIn),
    .CP0WE      (CP0WE),
    .PC         (PC),
    .isIDS      (isIDS),
    .excCode    (excCode),
    .EXLClr     (EXLClr),
    .HWInt      (HWInt),
    .DOut       (DOut),
    .EPCOut     (EPCOut),
    .requestInt (requestInt),
    .handlerPC  (handlerPC)
  );

  always #5 clk = ~clk;

  // Reference model: whole architectural registers as plain words.
  bit          m_valid = 0;
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  bit          m_tpend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] m_hw();
`ifdef CP0_TIMER_INT_EN
    return HWInt | (m_tpend ? 6'h20 : 6'h00);
`else
    return HWInt;
`endif
  endfunction

  function automatic bit m_int();
    return ((m_hw() & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_int() || (excCode != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h2022_1108;
`ifdef CP0_TIMER_INT_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit          req, ir, wr;
    logic [31:0] sr_n, cause_n, epc_n;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tpend = 0;
      m_valid = 1;
      return;
    end
    req = m_req();
    ir  = m_int();
    wr  = CP0WE && !req;
    sr_n    = m_sr;
    epc_n   = m_epc;
    cause_n = (m_cause & ~32'h0000_FC00) | (32'(m_hw()) << 10);
    if (req) begin
      sr_n    = sr_n | 32'h2;
      cause_n = (cause_n & 32'h0000_FC00) | (isIDS ? 32'h8000_0000 : 32'h0)
                | (ir ? 32'h0 : 32'(excCode) << 2);
      epc_n   = (isIDS ? PC - 4 : PC) & 32'hFFFF_FFFC;
    end else begin
      if (wr && A2 == 5'd12) sr_n = DIn & 32'h0000_FC03;
      if (wr && A2 == 5'd14) epc_n = DIn;
      if (EXLClr) sr_n = sr_n & ~32'h2;
    end
    if (wr && A2 == 5'd11) m_tpend = 0;
    else if (m_count == m_compare) m_tpend = 1;
    if (wr && A2 == 5'd11) m_compare = DIn;
    m_count = (wr && A2 == 5'd9) ? DIn : m_count + 1;
    m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
  endtask

  // Called at a negedge with inputs set: check outputs, advance one clock, return at negedge.
  task automatic tick();
    #1;
    if (m_valid) begin
      check("requestInt", {31'b0, requestInt}, {31'b0, m_req()});
      check("DOut", DOut, m_read(A1));
      check("EPCOut", EPCOut, m_epc);
      check("handlerPC", handlerPC, 32'h0000_4180);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; A1 = 0; A2 = 0; DIn = 0; CP0WE = 0; PC = 0;
    isIDS = 0; excCode = 0; EXLClr = 0; HWInt = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); CP0WE = 1; A2 = a; DIn = d;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    tick(); tick();
    idle();
    A1 = 5'd12; #1 check("rst_sr", DOut, 32'h0);
    A1 = 5'd14; #1 check("rst_epc", DOut, 32'h0);
    check("rst_req", {31'b0, requestInt}, 32'h0);
    // Park Compare out of reach so the timer stays quiet in the directed tests.
    mtc0(5'd11, 32'hFFFF_0000);
    A1 = 5'd11; #1 check("cmp_read", DOut, m_read(5'd11));

    // Hardware interrupt entry.
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b000100; PC = 32'h3008; A1 = 5'd12;
    #1 check("t1_req", {31'b0, requestInt}, 32'h1);
    tick();
    idle(); A1 = 5'd14;
    #1 check("t1_epc", DOut, 32'h3008);
    check("t1_req_off", {31'b0, requestInt}, 32'h0);
    A1 = 5'd12; #1 check("t1_sr", DOut, 32'h0000_FC03);
    A1 = 5'd13; #1 check("t1_cause", DOut, 32'h0000_1000);

    // EXL masks exceptions; eret clears EXL and keeps EPC.
    excCode = 5'd10;
    #1 check("t4_masked", {31'b0, requestInt}, 32'h0);
    tick();
    idle(); EXLClr = 1; tick();
    idle(); A1 = 5'd12;
    #1 check("t4_sr", DOut, 32'h0000_FC01);
    check("t4_epc", EPCOut, 32'h3008);

    // Interrupt beats a simultaneous exception.
    HWInt = 6'b000001; excCode = 5'd4; PC = 32'h3020;
    #1 check("t2_req", {31'b0, requestInt}, 32'h1);
    tick();
    idle(); A1 = 5'd13;
    #1 check("t2_cause", DOut, 32'h0000_0400);
    check("t2_epc", EPCOut, 32'h3020);
    EXLClr = 1; tick();

    // Delay-slot exception with interrupts disabled.
    mtc0(5'd12, 32'h0000_FC00);
    excCode = 5'd12; PC = 32'h3010; isIDS = 1;
    #1 check("t3_req", {31'b0, requestInt}, 32'h1);
    tick();
    idle(); A1 = 5'd13;
    #1 check("t3_cause", DOut, 32'h8000_0030);
    check("t3_epc", EPCOut, 32'h300C);
    EXLClr = 1; tick();

    // Entry suppresses a same-cycle EPC write; PRId read.
    idle(); CP0WE = 1; A2 = 5'd14; DIn = 32'hDEAD_BEEF; excCode = 5'd4; PC = 32'h3040; A1 = 5'd15;
    #1 check("t5_prid", DOut, 32'h2022_1108);
    tick();
    idle();
    #1 check("t5_epc", EPCOut, 32'h3040);
    // SR write with eret: EXL clears, IM/IE from data.
    CP0WE = 1; A2 = 5'd12; DIn = 32'hFFFF_FC03; EXLClr = 1; tick();
    idle(); A1 = 5'd12;
    #1 check("t5_sr_eret", DOut, 32'h0000_FC01);

`ifndef CP0_TIMER_INT_EN
    mtc0(5'd9, 32'h1234_5678);
    A1 = 5'd9;  #1 check("no_count", DOut, 32'h0);
    A1 = 5'd11; #1 check("no_compare", DOut, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      A1      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(9 + $urandom_range(0, 6));
      A2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(9 + $urandom_range(0, 6));
      DIn     = $urandom;
      CP0WE   = ($urandom_range(0, 3) == 0);
      PC      = $urandom;
      isIDS   = 1'($urandom);
      excCode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      EXLClr  = ($urandom_range(0, 5) == 0);
      HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      tick();
    end

`ifdef CP0_TIMER_INT_EN
    begin
      int waited;
      idle(); reset = 1; tick();
      mtc0(5'd11, 32'd20);
      mtc0(5'd12, 32'h0000_8001);
      A1 = 5'd9;
      waited = 0;
      while (requestInt !== 1'b1 && waited < 60) begin
        tick();
        waited++;
      end
      check("tmr_fire", {31'b0, requestInt}, 32'h1);
      check("tmr_count", DOut, 32'd21);
      tick();
      mtc0(5'd11, 32'd1000);
      idle(); EXLClr = 1; tick();
      idle();
      #1 check("tmr_cleared", {31'b0, requestInt}, 32'h0);
      mtc0(5'd9, 32'hFFFF_FFFE);
      A1 = 5'd9;
      #1 check("tmr_load", DOut, 32'hFFFF_FFFE);
      tick(); tick();
      check("tmr_wrap", DOut, 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS core; sits beside the M stage.
- Holds SR, Cause, EPC and PRId, and accepts mtc0/mfc0 and eret.
- Arbitrates between external hardware interrupts and the exception code carried down the pipeline.
- Raises requestInt, which flushes the E/M and M/W pipeline registers on the same edge, and redirects fetch to the handler.

Parameters:
- PRID, 32'h2022_1108, read-only processor ID returned for register 15.
- HANDLER_ADDR, 32'h0000_4180, PC target on interrupt/exception entry.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- CP0WE  in  1  mtc0 write enable from the M stage.
- PC  in  32  PC of the instruction currently in the M stage.
- isIDS  in  1  M-stage instruction sits in a branch delay slot.
- excCode  in  5  M-stage exception code; 0 means none.
- EXLClr  in  1  eret in the M stage.
- HWInt  in  6  external interrupt lines, level-sensitive.
- DOut  out  32  mfc0 read data, combinational.
- EPCOut  out  32  current EPC, used as the eret target.
- requestInt  out  1  flush/redirect request, combinational.
- handlerPC  out  32  constant HANDLER_ADDR.

Behaviour:
- Register fields:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): PRID.
  - Any other number reads 0.
- Reset: SR, Cause and EPC become 0, so requestInt = 0.
- Request generation (combinational, same cycle):
  - intReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
  - excReq = (excCode != 0) & ~SR.EXL.
  - requestInt = intReq | excReq.
- Priority: interrupt wins over exception when both are pending.
- Entry edge (requestInt = 1):
  - SR.EXL <= 1.
  - Cause.ExcCode <= intReq ? 0 : excCode.
  - Cause.BD <= isIDS.
  - EPC <= (isIDS ? PC - 4 : PC) & ~32'h3.
- Every cycle: Cause.IP <= HWInt, including on entry edges.
- eret: EXLClr = 1 with requestInt = 0 gives SR.EXL <= 0 on the edge. EPC is unchanged.
- mtc0:
  - Writes A2 with DIn only when CP0WE = 1 and requestInt = 0.
  - Writable: SR (IM, EXL, IE only) and EPC (full word).
  - Cause and PRId ignore writes.
- Simultaneous events:
  - Entry suppresses both the mtc0 write and eret.
  - mtc0 SR plus EXLClr on the same edge: EXLClr wins for the EXL bit; IM and IE take DIn.
- mfc0 read: returns the pre-edge value (no bypass of a same-cycle write).
- Nested entry while EXL = 1: impossible by construction, since both request terms are masked.

Optional Feature:
- Macro: CP0_TIMER_INT_EN.
- When defined:
  - Adds Count(9) and Compare(11).
  - Count increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - mtc0 to Count loads DIn (increment suppressed on that edge).
  - When Count == Compare, timerPending latches to 1.
  - mtc0 to Compare loads DIn and clears timerPending; the clear wins over a same-edge set.
  - timerPending is ORed into HWInt[5] before the IP and request logic.
  - Reset clears Count, Compare and timerPending.
- When undefined:
  - Registers 9 and 11 read 0 and ignore writes.
  - HWInt is used unmodified.

Decomposition:
- Shared paras.v gets:
  - CP0 register numbers (`CP0_SR, `CP0_CAUSE, `CP0_EPC, `CP0_PRID, `CP0_COUNT, `CP0_COMPARE).
  - Field bit positions.
  - `EXCINT = 5'd0 (`EXCDEFAULT is already there).
- Sub-module cp0_timer (Count/Compare/pending) is instantiated only under CP0_TIMER_INT_EN.

Test Plan:
1. Reset, then mtc0 SR = 32'h0000_FC01, HWInt = 6'b000100, PC = 32'h3008, isIDS = 0 -> requestInt = 1 the same cycle; next cycle EPC = 32'h3008, ExcCode = 0, EXL = 1, requestInt = 0.
2. SR.IE = 1, IM = 6'h3F, HWInt = 6'b000001 together with excCode = 5'd4 -> interrupt wins: ExcCode = 0 and EPC = PC.
3. IE = 0, excCode = 5'd12, PC = 32'h3010, isIDS = 1 -> requestInt = 1; EPC = 32'h300C, Cause.BD = 1, ExcCode = 12.
4. EXL = 1, excCode = 5'd10 -> requestInt = 0. Then EXLClr = 1 -> EXL = 0 next cycle; EPCOut unchanged.
5. Same cycle: CP0WE = 1, A2 = 14, DIn = 32'hDEAD_BEEF, plus an excCode = 4 request -> EPC = PC, not DEADBEEF. mfc0 A1 = 15 returns 32'h2022_1108.
6. With CP0_TIMER_INT_EN: Compare = 20, SR = 32'h0000_8001 -> requestInt asserts when Count reaches 20. mtc0 Compare clears the pending bit. Wrap check starting from Count = 32'hFFFF_FFFE.
